// File: rtl/pmem_responder_pkg.sv
// Shared pmem line/address types and the responder state encoding.
package pmem_responder_pkg;

    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [15:0]  lc3b_pmem_addr;

    typedef enum logic [2:0] {
        s_init,
        s_idle,
        s_busy,
        s_resp,
        s_recover
    } pmem_resp_state_t;

endpackage

// File: rtl/pmem_responder_line_array.sv
// Single-port line store: 2^DEPTH_LOG2 x 128-bit synchronous RAM, read-first.
module pmem_line_array
    import pmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [127:0]          wdata_i,
    output logic [127:0]          rdata_o
);

    lc3b_pmem_line mem_q [2**DEPTH_LOG2];
    lc3b_pmem_line rdata_q;

    // No reset on purpose so the tools map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Slave end of the line-granular pmem handshake: fixed-latency single-cycle
// responses from a zero-filled line store, plus a sticky protocol checker.
//
// state     | meaning
// s_init    | zero-filling one line per cycle, requests ignored
// s_idle    | waiting for a read or write request
// s_busy    | counting latency with the request latched
// s_resp    | pmem_resp high; write commits at the end of this cycle
// s_recover | dead cycle while the initiator drops its request
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         init_done,
    output logic         proto_error
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    pmem_resp_state_t      state_q, state_d;
    logic [DEPTH_LOG2-1:0] fill_q, fill_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  op_read_q, op_read_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    lc3b_pmem_line         wdata_q, wdata_d;
    logic                  perr_q, perr_d;

    logic                  req_any;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  held_changed;
    logic                  resp_now;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    lc3b_pmem_line         ram_wdata;
    lc3b_pmem_line         ram_rdata;
    logic                  addr_unused;

    // Bits below the line offset and above the index simply alias.
    assign addr_unused  = ^pmem_address;
    assign req_any      = pmem_read | pmem_write;
    assign req_idx      = pmem_address[DEPTH_LOG2+3:4];
    assign held_changed = (pmem_read != op_read_q) | (req_idx != idx_q);

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        op_read_d = op_read_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        perr_d    = perr_q;
        ram_we    = 1'b0;
        ram_addr  = idx_q;
        ram_wdata = wdata_q;

        case (state_q)
            s_init: begin
                ram_we    = 1'b1;
                ram_addr  = fill_q;
                ram_wdata = '0;
                fill_d    = fill_q + 1'b1;
                if (fill_q == '1) begin
                    state_d = s_idle;
                end
            end
            s_idle: begin
                // Address the array now so a LATENCY=1 read lands in s_resp.
                ram_addr = req_idx;
                if (req_any) begin
                    op_read_d = pmem_read;
                    idx_d     = req_idx;
                    wdata_d   = pmem_wdata;
                    cnt_d     = 8'd1;
                    if (pmem_read && pmem_write) begin
                        perr_d = 1'b1;
                    end
                    state_d = (LATENCY == 1) ? s_resp : s_busy;
                end
            end
            s_busy: begin
                if (!req_any) begin
                    perr_d  = 1'b1;
                    state_d = s_idle;
                end else begin
                    if (held_changed) begin
                        perr_d = 1'b1;
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAT_M1) begin
                        state_d = s_resp;
                    end
                end
            end
            s_resp: begin
                if (!req_any) begin
                    perr_d  = 1'b1;
                    state_d = s_idle;
                end else begin
                    if (held_changed) begin
                        perr_d = 1'b1;
                    end
                    ram_we  = !op_read_q;
                    state_d = s_recover;
                end
            end
            s_recover: begin
                state_d = s_idle;
            end
            default: begin
                state_d = s_init;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= s_init;
            fill_q    <= '0;
            cnt_q     <= '0;
            op_read_q <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            op_read_q <= op_read_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            perr_q    <= perr_d;
        end
    end

    // Gating with reset_n keeps a reset that lands in s_resp from committing.
    pmem_line_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .we_i   (ram_we & reset_n),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    assign resp_now    = (state_q == s_resp) & req_any;
    assign pmem_resp   = resp_now;
    assign pmem_rdata  = (resp_now && op_read_q) ? ram_rdata : '0;
    assign init_done   = (state_q != s_init);
    assign proto_error = perr_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: LATENCY=4/256-line and LATENCY=1/16-line instances
// checked against a line-array model with response-timing rules.
module tb_pmem_responder;

    localparam int LAT = 4;
    localparam int NO  = 1000;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         r0, w0, r1, w1;
    logic [15:0]  a0, a1;
    logic [127:0] wd0, wd1;
    logic         resp0, resp1, done0, done1, perr0, perr1;
    logic [127:0] rdata0, rdata1;

    pmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .pmem_read(r0), .pmem_write(w0),
        .pmem_address(a0), .pmem_wdata(wd0), .pmem_resp(resp0),
        .pmem_rdata(rdata0), .init_done(done0), .proto_error(perr0)
    );

    pmem_responder #(.LATENCY(1), .DEPTH_LOG2(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pmem_read(r1), .pmem_write(w1),
        .pmem_address(a1), .pmem_wdata(wd1), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .init_done(done1), .proto_error(perr1)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    logic [127:0] ref_mem [2][256];
    logic         exp_perr [2];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [127:0] wd);
        if (w == 0) begin
            r0 = rd; w0 = wr; a0 = addr; wd0 = wd;
        end else begin
            r1 = rd; w1 = wr; a1 = addr; wd1 = wd;
        end
    endtask

    function automatic int idx_of(input int w, input logic [15:0] addr);
        return (w == 0) ? int'(addr[11:4]) : int'(addr[7:4]);
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            exp_perr[w] = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[w][i] = '0;
        end
    endtask

    // Called in the first cycle after reset release.
    task automatic wait_init();
        #1;
        chk("rst_resp0", resp0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_perr0", perr0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_perr1", perr1, 0);
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk); #1;
            if (k == 15 || k == 16) chk($sformatf("init_done1 k%0d", k), done1, (k == 16));
            if (k == 255 || k == 256) chk($sformatf("init_done0 k%0d", k), done0, (k == 256));
            if (k == 256) chk("done1_hold", done1, 1);
        end
    endtask

    // One transaction starting in an idle cycle; cycle 0 is the acceptance cycle.
    task automatic do_txn(input int w, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [127:0] wd,
                          input int drop_cyc, input int chg_cyc, input logic [15:0] chg_addr);
        int           lat;
        int           idx;
        logic [127:0] exp_rd;
        logic         req_on;
        logic         exp_resp;
        lat    = (w == 0) ? LAT : 1;
        idx    = idx_of(w, addr);
        exp_rd = ref_mem[w][idx];
        for (int c = 0; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            req_on = (c < drop_cyc) && (c <= lat);
            drive(w, req_on & rd, req_on & wr, (c >= chg_cyc) ? chg_addr : addr, wd);
            #1;
            exp_resp = (drop_cyc > lat) && (c == lat);
            chk($sformatf("resp%0d a%h c%0d", w, addr, c), (w == 0) ? resp0 : resp1, exp_resp);
            chk($sformatf("rdata%0d a%h c%0d", w, addr, c), (w == 0) ? rdata0 : rdata1,
                (exp_resp && rd) ? exp_rd : 128'd0);
        end
        if (rd && wr) exp_perr[w] = 1'b1;
        if (drop_cyc >= 1 && drop_cyc <= lat) exp_perr[w] = 1'b1;
        if (chg_cyc >= 1 && chg_cyc <= lat && idx_of(w, chg_addr) != idx) exp_perr[w] = 1'b1;
        if (wr && !rd && drop_cyc > lat) ref_mem[w][idx] = wd;
        chk($sformatf("perr%0d a%h", w, addr), (w == 0) ? perr0 : perr1, exp_perr[w]);
    endtask

    task automatic reset_mid_write(input logic [15:0] addr, input logic [127:0] wd);
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b1, addr, wd);
            if (c == 3) reset_n = 1'b0;
            #1;
            chk($sformatf("rstw_resp c%0d", c), resp0, 0);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b1;
        model_clear();
        wait_init();
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [15:0]  ra;
        logic         rrd;
        int           rw;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_init();

        do_txn(0, 1, 0, 16'h0040, '0, NO, NO, '0);
        do_txn(0, 0, 1, 16'h1230, 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233, NO, NO, '0);
        do_txn(0, 1, 0, 16'h123C, '0, NO, NO, '0);

        for (int n = 0; n < 40; n++) begin
            rw  = int'($urandom_range(0, 1));
            rrd = 1'($urandom_range(0, 1));
            ra  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ra[11:6] = '0;
            do_txn(rw, rrd, !rrd, ra, rand_line(), NO, NO, '0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        do_txn(0, 0, 1, 16'h0080, 128'h0808_1111_2222_3333_4444_5555_6666_7777, NO, NO, '0);
        do_txn(0, 1, 1, 16'h0080, {128{1'b1}}, NO, NO, '0);
        do_txn(0, 1, 0, 16'h0080, '0, NO, NO, '0);

        do_txn(0, 0, 1, 16'h0100, {128{1'b1}}, 2, NO, '0);
        do_txn(0, 1, 0, 16'h0100, '0, NO, NO, '0);

        do_txn(0, 0, 1, 16'h0200, 128'h0200_0200_0200_0200_0200_0200_0200_0200, NO, NO, '0);
        do_txn(0, 0, 1, 16'h0210, 128'h0210_0210_0210_0210_0210_0210_0210_0210, NO, NO, '0);
        do_txn(0, 1, 0, 16'h0200, '0, NO, 2, 16'h0210);

        do_txn(0, 0, 1, 16'h0300, 128'hCAFE_F00D_0000_0000_1234_5678_9ABC_DEF0, NO, NO, '0);
        reset_mid_write(16'h0300, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA);
        do_txn(0, 1, 0, 16'h0300, '0, NO, NO, '0);

        do_txn(1, 0, 1, 16'h0050, 128'h0001_0002_0003_0004_0005_0006_0007_0008, NO, NO, '0);
        do_txn(1, 1, 0, 16'h0050, '0, NO, NO, '0);
        do_txn(1, 1, 0, 16'h0150, '0, NO, NO, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
